// File: rtl/rate_selector.sv
// Glitch-free selector between the eight divided-clock levels from the clock hub.
// The selected level is re-timed onto clk_50MHz as hub_clk, and its rising edges
// are reported as one-cycle tick_o pulses. A rate change works in two steps:
// drain the old rate to a low phase, then arm until the new rate is low.
// Optional feature macro: RATE_SELECTOR_TICK_CNT_EN (builds the tick_o counter).
module rate_selector #(
    parameter logic [2:0]  SEL_RESET = 3'd0,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk_50MHz,
    input  logic             rst,
    input  logic [7:0]       rate_i,
    input  logic [2:0]       sel_i,
    output logic             hub_clk,
    output logic             tick_o,
    output logic             switching_o,
    output logic [2:0]       cur_sel_o,
    output logic [CNT_W-1:0] tick_cnt_o
);

    typedef enum logic [1:0] {StRun, StDrain, StArm} state_e;

    state_e     state_q, state_d;
    logic [7:0] r1_q, r1_d, r2_q, r2_d;
    logic [2:0] cur_sel_q, cur_sel_d;
    logic [2:0] pend_sel_q, pend_sel_d;
    logic       hub_clk_q, hub_clk_d;
    logic       tick_q, tick_d;
    logic       sel_lvl;
    logic       sel_rise;

    assign sel_lvl  = r1_q[cur_sel_q];
    assign sel_rise = r1_q[cur_sel_q] & ~r2_q[cur_sel_q];

    // Next-state logic: two-stage input sync plus the RUN/DRAIN/ARM switch FSM.
    always_comb begin
        r1_d       = rate_i;
        r2_d       = r1_q;
        state_d    = state_q;
        cur_sel_d  = cur_sel_q;
        pend_sel_d = pend_sel_q;
        hub_clk_d  = 1'b0;
        tick_d     = 1'b0;
        unique case (state_q)
            StRun: begin
                hub_clk_d = sel_lvl;
                tick_d    = sel_rise;
                if (sel_i != cur_sel_q) begin
                    state_d    = StDrain;
                    pend_sel_d = sel_i;
                end
            end
            StDrain: begin
                // Let the old rate finish its high phase before dropping hub_clk.
                pend_sel_d = sel_i;
                if (sel_lvl) begin
                    hub_clk_d = 1'b1;
                end else begin
                    cur_sel_d = pend_sel_q;
                    state_d   = StArm;
                end
            end
            StArm: begin
                // Hold hub_clk low until the new rate is itself low, so its first
                // high phase is seen whole.
                if (sel_i != cur_sel_q) begin
                    cur_sel_d = sel_i;
                end else if (!sel_lvl) begin
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            state_q    <= StRun;
            r1_q       <= '0;
            r2_q       <= '0;
            cur_sel_q  <= SEL_RESET;
            pend_sel_q <= SEL_RESET;
            hub_clk_q  <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            r1_q       <= r1_d;
            r2_q       <= r2_d;
            cur_sel_q  <= cur_sel_d;
            pend_sel_q <= pend_sel_d;
            hub_clk_q  <= hub_clk_d;
            tick_q     <= tick_d;
        end
    end

    assign hub_clk     = hub_clk_q;
    assign tick_o      = tick_q;
    assign switching_o = (state_q != StRun);
    assign cur_sel_o   = cur_sel_q;

`ifdef RATE_SELECTOR_TICK_CNT_EN
    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic             run_entry;

    assign run_entry = (state_q == StArm) && (state_d == StRun);

    // Tick counter: restarts when a switch completes, otherwise wraps freely.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (run_entry) begin
            tick_cnt_d = '0;
        end else if (tick_q) begin
            tick_cnt_d = tick_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Tick counter register.
    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    assign tick_cnt_o = tick_cnt_q;
`else
    assign tick_cnt_o = '0;
`endif

endmodule

// File: tb/tb_rate_selector.sv
// Directed bench for rate_selector: vector table for reset and steady 5MHz,
// plus hand-derived sequences for switching, mid-switch reselect and reset.
module tb_rate_selector;

    localparam int unsigned CntW = 4;
`ifdef RATE_SELECTOR_TICK_CNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [7:0]      rate;
    logic [2:0]      sel;
    logic            hub;
    logic            tick;
    logic            sw;
    logic [2:0]      cur;
    logic [CntW-1:0] cnt;

    int n_checks = 0;
    int n_fail   = 0;

    rate_selector #(
        .SEL_RESET(3'd0),
        .CNT_W    (CntW)
    ) u_dut (
        .clk_50MHz  (clk),
        .rst        (rst),
        .rate_i     (rate),
        .sel_i      (sel),
        .hub_clk    (hub),
        .tick_o     (tick),
        .switching_o(sw),
        .cur_sel_o  (cur),
        .tick_cnt_o (cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       rate0;
        logic       hub;
        logic       tick;
        logic [3:0] cnt;
    } vec_t;

    vec_t vecs[17];

    // 5MHz = 5/5, 1MHz = 25/25, 100kHz = 250/250 cycles, phase-locked to c.
    function automatic logic [7:0] gen_rate(input int c);
        logic [7:0] r;
        r    = '0;
        r[0] = (c % 10) < 5;
        r[1] = (c % 50) < 25;
        r[2] = (c % 500) < 250;
        return r;
    endfunction

    function automatic logic [3:0] cnt_exp(input int v);
        return CntEn ? 4'(v % 16) : 4'd0;
    endfunction

    // hub_clk while following 5MHz: copy of rate0 one sample back.
    function automatic logic r0_hub(input int c);
        return (c >= 1) && (((c - 1) % 10) < 5);
    endfunction

    function automatic logic [9:0] pk(input logic h, input logic t, input logic s,
                                      input logic [2:0] cs, input logic [3:0] cn);
        return {h, t, s, cs, cn};
    endfunction

    // Drive inputs at negedge, let one posedge pass, return at the next negedge.
    task automatic cycle(input logic rst_v, input logic [2:0] sel_v, input logic [7:0] rate_v);
        rst  = rst_v;
        sel  = sel_v;
        rate = rate_v;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input int c, input logic [9:0] exp);
        logic [9:0] act;
        act = {hub, tick, sw, cur, cnt};
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s c=%0d got hub=%b tick=%b sw=%b cur=%0d cnt=%0d exp hub=%b tick=%b sw=%b cur=%0d cnt=%0d",
                     name, c, act[9], act[8], act[7], act[6:4], act[3:0],
                     exp[9], exp[8], exp[7], exp[6:4], exp[3:0]);
        end
    endtask

    task automatic check_val(input string name, input int c, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s c=%0d got %0d exp %0d", name, c, act, exp);
        end
    endtask

    task automatic do_reset();
        cycle(1'b1, 3'd0, 8'd0);
        cycle(1'b1, 3'd0, 8'd0);
        check("reset", -1, pk(1'b0, 1'b0, 1'b0, 3'd0, 4'd0));
    endtask

    initial begin
        logic       h, t, s;
        logic [2:0] cu;
        logic [2:0] sv;
        int         cn;
        int         nt, last, sw_seen;

        // rst, rate0, hub, tick, cnt (ticks counted so far)
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd1};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd1};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd1};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd1};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd1};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd1};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd1};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd1};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd1};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd2};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd2};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd2};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd2};

        // Table: reset with 5MHz already high, then steady 5/5 tracking.
        for (int i = 0; i < 17; i++) begin
            cycle(vecs[i].rst, 3'd0, {7'd0, vecs[i].rate0});
            check("table", i, pk(vecs[i].hub, vecs[i].tick, 1'b0, 3'd0, cnt_exp(int'(vecs[i].cnt))));
        end

        // 1000 cycles at sel=0: 100 ticks, 10 apart, no switching, counter wraps.
        do_reset();
        nt = 0; last = -1; sw_seen = 0;
        for (int c = 0; c < 1000; c++) begin
            cycle(1'b0, 3'd0, gen_rate(c));
            if (sw) sw_seen++;
            if (tick) begin
                check_val("tick_cnt", c, int'(cnt), int'(cnt_exp(nt)));
                if (last >= 0) check_val("tick_spacing", c, c - last, 10);
                last = c;
                nt++;
            end
        end
        check_val("tick_total", 1000, nt, 100);
        check_val("switching_seen", 1000, sw_seen, 0);
        check_val("cnt_final", 1000, int'(cnt), int'(cnt_exp(100)));

        // 5MHz -> 1MHz requested while 5MHz is high.
        do_reset();
        for (int c = 0; c <= 80; c++) begin
            cycle(1'b0, (c >= 10) ? 3'd1 : 3'd0, gen_rate(c));
            h  = (c <= 15) ? r0_hub(c) : ((c >= 51) && (((c - 1) % 50) < 25));
            t  = (c == 1) || (c == 51);
            s  = (c >= 10) && (c <= 25);
            cu = (c >= 16) ? 3'd1 : 3'd0;
            cn = (((c >= 2) && (c <= 25)) || (c >= 52)) ? 1 : 0;
            check("switch_0_to_1", c, pk(h, t, s, cu, cnt_exp(cn)));
        end

        // Reselect 1 -> 2 during DRAIN; index 1 never ticks.
        do_reset();
        for (int c = 0; c <= 510; c++) begin
            sv = (c < 10) ? 3'd0 : ((c < 12) ? 3'd1 : 3'd2);
            cycle(1'b0, sv, gen_rate(c));
            h  = (c <= 15) ? r0_hub(c) : ((c >= 501) && (((c - 1) % 500) < 250));
            t  = (c == 1) || (c == 501);
            s  = (c >= 10) && (c <= 250);
            cu = (c >= 16) ? 3'd2 : 3'd0;
            cn = (((c >= 2) && (c <= 250)) || (c >= 502)) ? 1 : 0;
            check("reselect_in_drain", c, pk(h, t, s, cu, cnt_exp(cn)));
        end

        // Request returns to the old rate during DRAIN: still goes through ARM.
        do_reset();
        for (int c = 0; c <= 35; c++) begin
            sv = ((c >= 10) && (c < 12)) ? 3'd1 : 3'd0;
            cycle(1'b0, sv, gen_rate(c));
            t  = (c == 1) || (c == 21) || (c == 31);
            s  = (c >= 10) && (c <= 16);
            if (c <= 1) cn = 0;
            else if (c <= 16) cn = 1;
            else if (c <= 21) cn = 0;
            else if (c <= 31) cn = 1;
            else cn = 2;
            check("return_to_old", c, pk(r0_hub(c), t, s, 3'd0, cnt_exp(cn)));
        end

        // One-cycle reset while in ARM aborts the switch.
        do_reset();
        for (int c = 0; c <= 24; c++) begin
            sv = ((c >= 10) && (c < 20)) ? 3'd1 : 3'd0;
            cycle((c == 20), sv, gen_rate(c));
            unique case (c)
                19: check("reset_in_arm", c, pk(1'b0, 1'b0, 1'b1, 3'd1, cnt_exp(1)));
                20: check("reset_in_arm", c, pk(1'b0, 1'b0, 1'b0, 3'd0, 4'd0));
                21: check("reset_in_arm", c, pk(1'b0, 1'b0, 1'b0, 3'd0, 4'd0));
                22: check("reset_in_arm", c, pk(1'b1, 1'b1, 1'b0, 3'd0, 4'd0));
                23: check("reset_in_arm", c, pk(1'b1, 1'b0, 1'b0, 3'd0, cnt_exp(1)));
                24: check("reset_in_arm", c, pk(1'b1, 1'b0, 1'b0, 3'd0, cnt_exp(1)));
                default: ;
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rate_selector.md
RATE_SELECTOR -- requirements
Module: rate_selector

Interface
REQ-001 Parameter SEL_RESET, default 3'd0, rate index selected out of reset (0 = clk_5MHz).
REQ-002 Parameter CNT_W, default 16, width of tick_cnt_o.
REQ-003 clk_50MHz  in  1  single system clock; all logic on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 rate_i  in  8  divided-clock levels from the clock hub: [0]=5MHz, [1]=1MHz, [2]=100kHz, [3]=10kHz, [4]=1kHz, [5]=100Hz, [6]=10Hz, [7]=1Hz; all are synchronous to clk_50MHz and sampled as data.
REQ-006 sel_i  in  3  requested rate index.
REQ-007 hub_clk  out  1  glitch-free level of the selected rate; drives dut_clk.
REQ-008 tick_o  out  1  one-cycle pulse per rising edge of the selected rate; drives sampling_clk.
REQ-009 switching_o  out  1  high while a rate change is in progress.
REQ-010 cur_sel_o  out  3  rate index currently in effect.
REQ-011 tick_cnt_o  out  CNT_W  count of tick_o pulses since reset or the last completed switch.

Function
REQ-012 rate_i is registered twice (r1, r2); the rising edge of index k is r1[k] & ~r2[k].
REQ-013 In RUN, hub_clk is registered from r1[cur_sel]; it follows rate_i[cur_sel] with 2 cycles of latency.
REQ-014 In RUN, tick_o is registered from the rising edge of cur_sel; it is high exactly 1 cycle, 2 cycles after rate_i[cur_sel] rises, aligned with hub_clk rising.
REQ-015 The FSM has states RUN, DRAIN and ARM; switching_o = (state != RUN).
REQ-016 RUN -> DRAIN when sel_i != cur_sel; pend_sel <= sel_i.
REQ-017 In DRAIN, hub_clk keeps following the old rate; pend_sel tracks sel_i every cycle; when r1[cur_sel]==0, hub_clk <= 0, cur_sel <= pend_sel, and the FSM goes to ARM.
REQ-018 In ARM, hub_clk is held 0; if sel_i != cur_sel, cur_sel <= sel_i and the FSM stays in ARM; otherwise, when r1[cur_sel]==0, the FSM goes to RUN.
REQ-019 tick_o is 0 in DRAIN and ARM; a rising edge of the new rate is honoured only from the first RUN cycle onward.
REQ-020 hub_clk never produces a high or low phase shorter than the shorter phase of the old or new rate.
REQ-021 If sel_i returns to the old value during DRAIN, the switch still completes via ARM, with no fast path.
REQ-022 If sel_i == cur_sel in RUN, the FSM does not change state.

Reset
REQ-023 While rst is high: state = RUN, cur_sel = pend_sel = SEL_RESET, r1 = r2 = 0, hub_clk = 0, tick_o = 0, switching_o = 0, tick_cnt_o = 0.
REQ-024 Reset asserted mid-switch aborts the switch; the first cycle after release is RUN with cur_sel = SEL_RESET.
REQ-025 Because r2 = 0 after reset, a selected rate that is already high on release produces a tick 2 cycles after release.

Configuration
REQ-026 Macro RATE_SELECTOR_TICK_CNT_EN controls the tick counter.
- Defined: tick_cnt_o increments on every tick_o, wraps from 2^CNT_W-1 to 0, and clears on the ARM->RUN transition.
- Undefined: no counter logic is built; tick_cnt_o is tied to 0 and the port is kept.

Verification
REQ-027 Reset release, sel_i=0, 5MHz input (5 high / 5 low cycles) -> tick_o pulses every 10 cycles; hub_clk is a 5/5 copy delayed by 2 cycles; switching_o=0.
REQ-028 From 5MHz, set sel_i=1 (1MHz, 25/25) while 5MHz is high -> hub_clk finishes its high phase, then stays 0 until 1MHz is low; no tick during the switch; switching_o falls, then the next tick is 2 cycles after the 1MHz rise; cur_sel_o=1.
REQ-029 During DRAIN, change sel_i 1->2 -> cur_sel_o=2 at the switch end; no tick from index 1 is emitted.
REQ-030 Assert rst for 1 cycle while in ARM -> next cycle is RUN, cur_sel_o=SEL_RESET, all outputs 0, tick_cnt_o=0.
REQ-031 With RATE_SELECTOR_TICK_CNT_EN defined, CNT_W=4, 17 ticks at 5MHz -> tick_cnt_o reads 15, then 0, then 1; with the macro undefined -> tick_cnt_o stays 0.
REQ-032 Hold sel_i=0 across 1000 cycles -> switching_o never asserts and there are exactly 100 ticks.
